// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage core (master) and the hazard sequencer (slave).
// The core drives hazard and status inputs; the sequencer returns the stage enables.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             ex_MemRead;
  logic [4:0]       ex_wr;
  logic             ex_br_taken;
  logic             mem_busy;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_write;
  logic             id_ex_bubble;
  logic             ex_mem_write;
  logic             err;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_MemRead, ex_wr, ex_br_taken, mem_busy,
    input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write,
    input  err, state, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_MemRead, ex_wr, ex_br_taken, mem_busy,
    output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write,
    output err, state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage RV32 core: load-use stalls, taken-branch squash,
// memory-busy freeze with timeout watchdog, and saturating stall/flush event counters.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8,
  parameter int CNT_W       = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b10
  } state_t;

  state_t            st;
  logic [TO_W-1:0]   to_cnt;
  logic [TO_W-1:0]   to_next;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
  logic              err;
  logic              luh;
  logic              busy_act;
  logic              br_act;
  logic              stall_act;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    luh = bus.ex_MemRead && (bus.ex_wr != 5'd0) &&
          ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_wr)) ||
           (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_wr)));
    busy_act  = (st != ERROR) && bus.mem_busy;
    br_act    = (st != ERROR) && !bus.mem_busy && bus.ex_br_taken;
    stall_act = (st != ERROR) && !bus.mem_busy && !bus.ex_br_taken && luh;
    // First busy cycle seen from RUN counts as 1
    to_next   = (st == RUN) ? TO_W'(1) : to_cnt + 1'b1;
  end

  // Stage enables act in the same cycle as the inputs that cause them
  always_comb begin
    bus.pc_write     = 1'b1;
    bus.if_id_write  = 1'b1;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_write  = 1'b1;
    bus.id_ex_bubble = 1'b0;
    bus.ex_mem_write = 1'b1;
    if (!rst_n) begin
      bus.pc_write     = 1'b0;
      bus.if_id_write  = 1'b0;
      bus.if_id_flush  = 1'b1;
      bus.id_ex_bubble = 1'b1;
    end else if (st == ERROR || busy_act) begin
      bus.pc_write     = 1'b0;
      bus.if_id_write  = 1'b0;
      bus.id_ex_write  = 1'b0;
      bus.ex_mem_write = 1'b0;
    end else if (br_act) begin
      bus.if_id_flush  = 1'b1;
      bus.id_ex_bubble = 1'b1;
    end else if (stall_act) begin
      bus.pc_write     = 1'b0;
      bus.if_id_write  = 1'b0;
      bus.id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st        <= RUN;
      to_cnt    <= '0;
      err       <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (st)
        RUN, MEM_WAIT: begin
          if (bus.mem_busy) begin
            to_cnt <= to_next;
            if (to_next == TO_W'(MEM_TIMEOUT)) begin
              st  <= ERROR;
              err <= 1'b1;
            end else begin
              st <= MEM_WAIT;
            end
          end else begin
            st     <= RUN;
            to_cnt <= '0;
          end
        end
        default: st <= ERROR;
      endcase
      if (br_act)    flush_cnt <= sat_inc(flush_cnt);
      if (stall_act) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign bus.state     = st;
  assign bus.err       = err;
  assign bus.stall_cnt = stall_cnt;
  assign bus.flush_cnt = flush_cnt;

endmodule
